// File: rtl/skolem_sweep_checker.sv
// Exhaustive sweep checker for a single-output Skolem function: evaluates phi(x,0),
// phi(x,1) and phi(x,f(x)) for every x and counts failing and unrealizable assignments.
module skolem_sweep_checker #(
    parameter int N_IN = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    output logic [N_IN-1:0] x_out,
    output logic            y_drv,
    input  logic            f_in,
    input  logic            phi_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   fail_cnt,
    output logic [N_IN:0]   unreal_cnt,
    output logic [N_IN-1:0] first_cex,
    output logic            cex_valid
);

    typedef enum logic [2:0] {IDLE, EV0, EV1, EVF, DONE} state_t;

    localparam logic [N_IN-1:0] X_MAX = '1;

    state_t          state_q, state_d;
    logic [N_IN-1:0] x_q, x_d;
    logic [N_IN-1:0] cex_q, cex_d;
    logic            cex_valid_q, cex_valid_d;
    logic [N_IN:0]   fail_q, fail_d;
    logic [N_IN:0]   unreal_q, unreal_d;
    logic            s0_q, s0_d;
    logic            s1_q, s1_d;
    logic            witness;

    assign witness = s0_q | s1_q;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        cex_d       = cex_q;
        cex_valid_d = cex_valid_q;
        fail_d      = fail_q;
        unreal_d    = unreal_q;
        s0_d        = s0_q;
        s1_d        = s1_q;
        case (state_q)
            IDLE, DONE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d     = EV0;
                    x_d         = '0;
                    cex_d       = '0;
                    cex_valid_d = 1'b0;
                    fail_d      = '0;
                    unreal_d    = '0;
                end
            end
            EV0: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    s0_d    = phi_in;
                    state_d = EV1;
                end
            end
            EV1: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    s1_d    = phi_in;
                    state_d = EVF;
                end
            end
            EVF: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    // phi_in here is phi(x, f(x)) since y_drv follows f_in this cycle
                    if (witness && !phi_in) begin
                        fail_d = fail_q + (N_IN+1)'(1);
                        if (!cex_valid_q) begin
                            cex_d       = x_q;
                            cex_valid_d = 1'b1;
                        end
                    end
                    if (!witness) begin
                        unreal_d = unreal_q + (N_IN+1)'(1);
                    end
                    if (x_q == X_MAX) begin
                        state_d = DONE;
                    end else begin
                        x_d     = x_q + N_IN'(1);
                        state_d = EV0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            cex_q       <= '0;
            cex_valid_q <= 1'b0;
            fail_q      <= '0;
            unreal_q    <= '0;
            s0_q        <= 1'b0;
            s1_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            cex_q       <= cex_d;
            cex_valid_q <= cex_valid_d;
            fail_q      <= fail_d;
            unreal_q    <= unreal_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
        end
    end

    always_comb begin
        case (state_q)
            EV1:     y_drv = 1'b1;
            EVF:     y_drv = f_in;
            default: y_drv = 1'b0;
        endcase
    end

    assign x_out      = x_q;
    assign busy       = (state_q == EV0) || (state_q == EV1) || (state_q == EVF);
    assign done       = (state_q == DONE);
    assign pass       = done && (fail_q == '0);
    assign fail_cnt   = fail_q;
    assign unreal_cnt = unreal_q;
    assign first_cex  = cex_q;
    assign cex_valid  = cex_valid_q;

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// Directed bench for skolem_sweep_checker with a behavioural phi/f environment
// and a scoreboard of expected sweep results.
module tb_skolem_sweep_checker;

    localparam int N_IN = 8;
    localparam int NX   = 1 << N_IN;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [N_IN-1:0] x_out;
    logic            y_drv;
    logic            f_in;
    logic            phi_in;
    logic            busy, done, pass, cex_valid;
    logic [N_IN:0]   fail_cnt, unreal_cnt;
    logic [N_IN-1:0] first_cex;

    int phi_mode = 0;  // 0: phi = (y == x[0]); 1: phi = 0
    int f_mode   = 1;  // 1: f = x[0];          0: f = 0

    int checks = 0;
    int errors = 0;

    typedef struct {
        int fail;
        int unreal;
        int cex;
        bit cexv;
        bit pass;
    } exp_t;

    exp_t sb[$];

    skolem_sweep_checker #(.N_IN(N_IN)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .x_out(x_out), .y_drv(y_drv), .f_in(f_in), .phi_in(phi_in),
        .busy(busy), .done(done), .pass(pass),
        .fail_cnt(fail_cnt), .unreal_cnt(unreal_cnt),
        .first_cex(first_cex), .cex_valid(cex_valid)
    );

    always #5 clk = ~clk;

    function automatic bit phi_model(int pm, int x, bit y);
        if (pm == 0) return (y == x[0]);
        return 1'b0;
    endfunction

    function automatic bit f_model(int fm, int x);
        if (fm == 1) return x[0];
        return 1'b0;
    endfunction

    always_comb begin
        f_in   = f_model(f_mode, int'(x_out));
        phi_in = phi_model(phi_mode, int'(x_out), y_drv);
    end

    function automatic exp_t predict(int pm, int fm);
        exp_t e;
        bit s0, s1, sf;
        e.fail = 0; e.unreal = 0; e.cex = 0; e.cexv = 1'b0;
        for (int x = 0; x < NX; x++) begin
            s0 = phi_model(pm, x, 1'b0);
            s1 = phi_model(pm, x, 1'b1);
            sf = phi_model(pm, x, f_model(fm, x));
            if ((s0 | s1) && !sf) begin
                e.fail++;
                if (!e.cexv) begin e.cex = x; e.cexv = 1'b1; end
            end
            if (!(s0 | s1)) e.unreal++;
        end
        e.pass = (e.fail == 0);
        return e;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_pass"}, 32'(pass), 0);
        check({tag, "_fail"}, 32'(fail_cnt), 0);
        check({tag, "_unreal"}, 32'(unreal_cnt), 0);
        check({tag, "_cex"}, 32'(first_cex), 0);
        check({tag, "_cexv"}, 32'(cex_valid), 0);
        check({tag, "_x"}, 32'(x_out), 0);
        check({tag, "_y"}, 32'(y_drv), 0);
    endtask

    // Pulse start for one cycle and push the predicted result of the new sweep.
    task automatic launch(string tag);
        sb.push_back(predict(phi_mode, f_mode));
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, "_busy_on_start"}, 32'(busy), 1);
        check({tag, "_done_cleared"}, 32'(done), 0);
        check({tag, "_x_zero"}, 32'(x_out), 0);
    endtask

    // Wait for done (bounded), optionally pulsing start mid-sweep, then score.
    task automatic finish_sweep(string tag, bit poke);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = poke && (cyc == 5 || cyc == 300);
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(cyc), 32'(3 * NX));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 1);
        end else begin
            e = sb.pop_front();
            check({tag, "_fail_cnt"}, 32'(fail_cnt), 32'(e.fail));
            check({tag, "_unreal_cnt"}, 32'(unreal_cnt), 32'(e.unreal));
            check({tag, "_first_cex"}, 32'(first_cex), 32'(e.cex));
            check({tag, "_cex_valid"}, 32'(cex_valid), 32'(e.cexv));
            check({tag, "_pass"}, 32'(pass), 32'(e.pass));
        end
        check({tag, "_busy_off"}, 32'(busy), 0);
        check({tag, "_x_hold"}, 32'(x_out), 32'(NX - 1));
        check({tag, "_y_idle"}, 32'(y_drv), 0);
    endtask

    initial begin
        // reset state
        #1;
        check_idle_zero("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_zero("idle_no_start");

        // case 1: correct Skolem function
        phi_mode = 0; f_mode = 1;
        launch("c1");
        finish_sweep("c1", 1'b0);

        // case 2: constant-0 function fails on odd x
        phi_mode = 0; f_mode = 0;
        launch("c2");
        finish_sweep("c2", 1'b0);

        // case 3: unsatisfiable predicate
        phi_mode = 1; f_mode = 1;
        launch("c3");
        finish_sweep("c3", 1'b0);

        // case 4: abort sampled 10 edges after the start-accepting edge
        phi_mode = 0; f_mode = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("c4_busy", 32'(busy), 0);
        check("c4_done", 32'(done), 0);
        check("c4_pass", 32'(pass), 0);
        check("c4_fail_cnt", 32'(fail_cnt), 1);
        check("c4_first_cex", 32'(first_cex), 1);
        check("c4_cex_valid", 32'(cex_valid), 1);
        repeat (3) @(negedge clk);
        check("c4_stays_idle", 32'(busy), 0);
        launch("c4r");
        check("c4r_fail_cleared", 32'(fail_cnt), 0);
        check("c4r_cexv_cleared", 32'(cex_valid), 0);
        finish_sweep("c4r", 1'b0);

        // case 5: start while busy ignored, start in DONE restarts
        phi_mode = 0; f_mode = 1;
        launch("c5");
        finish_sweep("c5", 1'b1);
        phi_mode = 0; f_mode = 0;
        launch("c5r");
        finish_sweep("c5r", 1'b0);

        // case 6: async reset mid-sweep
        launch("c6");
        repeat (400) @(negedge clk);
        check("c6_pre_fail_nonzero", 32'(fail_cnt != 0), 1);
        #2 rst_n = 1'b0;
        #1;
        check_idle_zero("c6_async");
        void'(sb.pop_front());
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_idle_zero("c6_after_release");

        phi_mode = 0; f_mode = 1;
        launch("c6r");
        finish_sweep("c6r", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
